// File: rtl/frame_loader.sv
// Frame loader: steers a framed 32-bit word stream into the LED controller's
// chunk-write port, walking chunk, then row, then panel, with resync and idle-timeout recovery.
module frame_loader #(
    parameter int CHUNKS  = 16,
    parameter int ROWS    = 16,
    parameter int PANELS  = 4,
    parameter int TIMEOUT = 65535,
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int PW = (PANELS > 1) ? $clog2(PANELS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   in_data,
    input  logic          in_sof,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          hold,
    output logic [31:0]   chunk_data,
    output logic [CW-1:0] chunk_addr,
    output logic [RW-1:0] row_addr,
    output logic [PW-1:0] panel_addr,
    output logic          chunk_write_enable,
    output logic          busy,
    output logic          frame_done,
    output logic          sync_error,
    output logic          timeout_error,
    output logic [15:0]   frame_count
);

    localparam int N  = CHUNKS * ROWS * PANELS;
    localparam int WW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] LAST_W  = WW'(N - 1);
    localparam logic [TW-1:0] LAST_TO = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [WW-1:0] w_r;
    logic [WW-1:0] w_next_s;
    logic [TW-1:0] to_r;
    logic [TW-1:0] to_next_s;
    logic [WW-1:0] wr_addr_s;
    logic [31:0]   addr32_s;
    logic [CW-1:0] chunk_s;
    logic [RW-1:0] row_s;
    logic [PW-1:0] panel_s;
    logic          xfer_s;
    logic          wr_s;
    logic          done_s;
    logic          sync_s;
    logic          tout_s;

    // Readiness depends only on hold so the upstream handshake never loops through in_valid.
    assign in_ready = ~hold;
    assign xfer_s   = in_valid & ~hold;
    assign busy     = (state_r == LOAD);

    // Word-index split: dimensions are powers of two, so these reduce to bit slices.
    assign addr32_s = 32'(wr_addr_s);
    assign chunk_s  = CW'(addr32_s % 32'(CHUNKS));
    assign row_s    = RW'((addr32_s / 32'(CHUNKS)) % 32'(ROWS));
    assign panel_s  = PW'(addr32_s / 32'(CHUNKS * ROWS));

    // State, word index and idle counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            w_r     <= '0;
            to_r    <= '0;
        end else begin
            state_r <= state_next_s;
            w_r     <= w_next_s;
            to_r    <= to_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && in_sof && (N > 1)) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (xfer_s) begin
                    if (!in_sof && (w_r == LAST_W)) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else if (!hold && (to_r == LAST_TO)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOAD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Write strobe, pulse, index and timeout decode; a transfer always clears the idle counter.
    always_comb begin
        wr_s      = 1'b0;
        done_s    = 1'b0;
        sync_s    = 1'b0;
        tout_s    = 1'b0;
        wr_addr_s = w_r;
        w_next_s  = w_r;
        to_next_s = '0;
        case (state_r)
            IDLE: begin
                if (xfer_s && in_sof) begin
                    wr_s      = 1'b1;
                    wr_addr_s = '0;
                    if (N == 1) begin
                        done_s   = 1'b1;
                        w_next_s = '0;
                    end else begin
                        w_next_s = WW'(1);
                    end
                end else begin
                    w_next_s = '0;
                end
            end
            LOAD: begin
                if (xfer_s) begin
                    wr_s = 1'b1;
                    if (in_sof) begin
                        sync_s    = 1'b1;
                        wr_addr_s = '0;
                        w_next_s  = WW'(1);
                    end else if (w_r == LAST_W) begin
                        done_s   = 1'b1;
                        w_next_s = '0;
                    end else begin
                        w_next_s = w_r + WW'(1);
                    end
                end else if (hold) begin
                    to_next_s = to_r;
                end else if (to_r == LAST_TO) begin
                    tout_s   = 1'b1;
                    w_next_s = '0;
                end else begin
                    to_next_s = to_r + TW'(1);
                end
            end
            default: begin
                w_next_s = '0;
            end
        endcase
    end

    // Registered write port, status pulses and frame counter; address/data hold between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chunk_data         <= 32'd0;
            chunk_addr         <= '0;
            row_addr           <= '0;
            panel_addr         <= '0;
            chunk_write_enable <= 1'b0;
            frame_done         <= 1'b0;
            sync_error         <= 1'b0;
            timeout_error      <= 1'b0;
            frame_count        <= 16'd0;
        end else begin
            chunk_write_enable <= wr_s;
            frame_done         <= done_s;
            sync_error         <= sync_s;
            timeout_error      <= tout_s;
            if (wr_s) begin
                chunk_data <= in_data;
                chunk_addr <= chunk_s;
                row_addr   <= row_s;
                panel_addr <= panel_s;
            end else begin
                chunk_data <= chunk_data;
                chunk_addr <= chunk_addr;
                row_addr   <= row_addr;
                panel_addr <= panel_addr;
            end
            if (done_s) begin
                frame_count <= frame_count + 16'd1;
            end else begin
                frame_count <= frame_count;
            end
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: a 16x16x4 instance and a single-chunk instance share one
// randomized stream and are checked cycle by cycle against a frame-position reference model.
module tb_frame_loader;

    localparam int CA = 16, RA = 16, PA = 4, NA = CA * RA * PA;
    localparam int TO = 8;

    typedef struct packed {
        logic        we;
        logic [15:0] w;
        logic [31:0] data;
        logic        done;
        logic        sync;
        logic        tout;
        logic        busy;
        logic [15:0] count;
        logic        rdy;
    } snap_t;

    typedef struct {
        bit          in_frame;
        int          pos;
        int          idle;
        int          count;
        logic [15:0] lw;
        logic [31:0] ld;
    } model_t;

    logic clk, reset_n, in_sof, in_valid, hold;
    logic [31:0] in_data;
    logic rdy_a, we_a, busy_a, done_a, sync_a, tout_a;
    logic [31:0] data_a;
    logic [3:0] ca_a, ra_a;
    logic [1:0] pa_a;
    logic [15:0] cnt_a;
    logic rdy_b, we_b, busy_b, done_b, sync_b, tout_b;
    logic [31:0] data_b;
    logic [0:0] ca_b, ra_b, pa_b;
    logic [15:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    model_t ma, mb;
    snap_t ea_q[$], oa_q[$], eb_q[$], ob_q[$];

    frame_loader #(.CHUNKS(CA), .ROWS(RA), .PANELS(PA), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sof(in_sof),
        .in_valid(in_valid), .in_ready(rdy_a), .hold(hold), .chunk_data(data_a),
        .chunk_addr(ca_a), .row_addr(ra_a), .panel_addr(pa_a),
        .chunk_write_enable(we_a), .busy(busy_a), .frame_done(done_a),
        .sync_error(sync_a), .timeout_error(tout_a), .frame_count(cnt_a));

    frame_loader #(.CHUNKS(1), .ROWS(1), .PANELS(1), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sof(in_sof),
        .in_valid(in_valid), .in_ready(rdy_b), .hold(hold), .chunk_data(data_b),
        .chunk_addr(ca_b), .row_addr(ra_b), .panel_addr(pa_b),
        .chunk_write_enable(we_b), .busy(busy_b), .frame_done(done_b),
        .sync_error(sync_b), .timeout_error(tout_b), .frame_count(cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t obs_a();
        snap_t o;
        o.we = we_a; o.w = 16'(int'(pa_a) * CA * RA + int'(ra_a) * CA + int'(ca_a));
        o.data = data_a; o.done = done_a; o.sync = sync_a; o.tout = tout_a;
        o.busy = busy_a; o.count = cnt_a; o.rdy = rdy_a;
        return o;
    endfunction

    function automatic snap_t obs_b();
        snap_t o;
        o.we = we_b; o.w = 16'(int'(pa_b) + int'(ra_b) + int'(ca_b));
        o.data = data_b; o.done = done_b; o.sync = sync_b; o.tout = tout_b;
        o.busy = busy_b; o.count = cnt_b; o.rdy = rdy_b;
        return o;
    endfunction

    // Reference: a frame is an ordered list of n slots; sof restarts at slot 0.
    task automatic mstep(inout model_t m, input int n, input logic v, input logic s,
                         input logic h, input logic [31:0] d, output snap_t e);
        e = '0;
        if (v && !h) begin
            m.idle = 0;
            if (s || m.in_frame) begin
                e.sync = s && m.in_frame;
                if (s) m.pos = 0;
                e.we = 1'b1;
                m.lw = 16'(m.pos);
                m.ld = d;
                m.pos++;
                m.in_frame = 1'b1;
                if (m.pos == n) begin
                    e.done = 1'b1;
                    m.count = (m.count + 1) % 65536;
                    m.pos = 0;
                    m.in_frame = 1'b0;
                end
            end
        end else if (m.in_frame && !h) begin
            m.idle++;
            if (m.idle == TO) begin
                e.tout = 1'b1;
                m.in_frame = 1'b0;
                m.pos = 0;
            end
        end
        if (!m.in_frame) m.idle = 0;
        e.w = m.lw; e.data = m.ld; e.busy = m.in_frame;
        e.count = 16'(m.count); e.rdy = !h;
    endtask

    task automatic mreset();
        ma = '{default: 0};
        mb = '{default: 0};
    endtask

    task automatic cyc(input logic v, input logic s, input logic [31:0] d, input logic h);
        snap_t e;
        in_valid = v; in_sof = s; in_data = d; hold = h;
        mstep(ma, NA, v, s, h, d, e); ea_q.push_back(e);
        mstep(mb, 1, v, s, h, d, e); eb_q.push_back(e);
        @(posedge clk); #1;
        oa_q.push_back(obs_a());
        ob_q.push_back(obs_b());
    endtask

    task automatic clearq();
        ea_q.delete(); oa_q.delete(); eb_q.delete(); ob_q.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sof = 1'b0; hold = 1'b0; in_data = 32'd0;
        reset_n = 1'b0;
        mreset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        snap_t z;
        do_reset();
        z = '0; z.rdy = 1'b1;
        n_cmp++; if (obs_a() !== z) begin n_bad++; $display("FAIL reset_a got %h want %h", obs_a(), z); end
        n_cmp++; if (obs_b() !== z) begin n_bad++; $display("FAIL reset_b got %h want %h", obs_b(), z); end
    endtask

    task automatic test_frame();
        int strobes;
        clearq();
        cyc(1'b1, 1'b1, 32'd0, 1'b0);
        for (int i = 1; i < NA; i++) cyc(1'b1, 1'b0, 32'(i), 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        strobes = 0;
        for (int i = 0; i < oa_q.size(); i++) strobes += int'(oa_q[i].we);
        n_cmp++; if (strobes != NA) begin n_bad++; $display("FAIL frame_strobes got %0d want %0d", strobes, NA); end
        n_cmp++; if (oa_q[17].w !== 16'd17 || oa_q[NA-1].done !== 1'b1) begin n_bad++; $display("FAIL frame_addr17_done got w=%0d done=%b want w=17 done=1", oa_q[17].w, oa_q[NA-1].done); end
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL frame_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
            n_cmp++; if (ob_q[i] !== eb_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL frame_b cyc %0d got %h want %h", i, ob_q[i], eb_q[i]); end
        end
    endtask

    task automatic test_discard();
        clearq();
        repeat (5) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < NA; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL discard_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
            n_cmp++; if (ob_q[i] !== eb_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL discard_b cyc %0d got %h want %h", i, ob_q[i], eb_q[i]); end
        end
    endtask

    task automatic test_resync();
        int syncs;
        logic [15:0] c0;
        clearq();
        c0 = cnt_a;
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < 300; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < NA; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        syncs = 0;
        for (int i = 0; i < oa_q.size(); i++) syncs += int'(oa_q[i].sync);
        n_cmp++; if (syncs != 1 || oa_q[300].w !== 16'd0) begin n_bad++; $display("FAIL resync_pulse got %0d pulses w=%0d want 1 pulses w=0", syncs, oa_q[300].w); end
        n_cmp++; if (cnt_a !== c0 + 16'd1) begin n_bad++; $display("FAIL resync_count got %0d want %0d", cnt_a, c0 + 16'd1); end
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL resync_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int touts;
        clearq();
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < 10; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        repeat (12) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, $urandom, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        touts = 0;
        for (int i = 0; i < oa_q.size(); i++) touts += int'(oa_q[i].tout);
        n_cmp++; if (touts != 1 || oa_q[9 + TO].tout !== 1'b1) begin n_bad++; $display("FAIL timeout_pulse got %0d pulses want 1 at cyc %0d", touts, 9 + TO); end
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL timeout_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
        end
    endtask

    task automatic test_hold();
        int held_we;
        clearq();
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < 100; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        repeat (50) cyc(1'b1, 1'b0, $urandom, 1'b1);
        for (int i = 100; i < NA; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        held_we = 0;
        for (int i = 100; i < 150; i++) held_we += int'(oa_q[i].we) + int'(oa_q[i].tout) + int'(oa_q[i].rdy);
        n_cmp++; if (held_we != 0 || oa_q[150].w !== 16'd100) begin n_bad++; $display("FAIL hold_freeze got %0d events w=%0d want 0 events w=100", held_we, oa_q[150].w); end
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL hold_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
        end
    endtask

    task automatic test_random();
        logic v, s, h;
        clearq();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0) && ((i % 700) < 688);
            s = ($urandom_range(0, 399) == 0);
            h = ($urandom_range(0, 9) == 0);
            cyc(v, s, $urandom, h);
        end
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL random_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
            n_cmp++; if (ob_q[i] !== eb_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL random_b cyc %0d got %h want %h", i, ob_q[i], eb_q[i]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        clearq();
        for (int i = 0; i < 65536; i++) cyc(1'b1, 1'b1, $urandom, 1'b0);
        n_cmp++; if (ob_q[65534].count !== 16'hFFFF || ob_q[65535].count !== 16'h0000) begin n_bad++; $display("FAIL wrap_count got %h then %h want ffff then 0000", ob_q[65534].count, ob_q[65535].count); end
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (ob_q[i] !== eb_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL wrap_b cyc %0d got %h want %h", i, ob_q[i], eb_q[i]); end
        end
        n_cmp++; if (oa_q[65535] !== ea_q[65535]) begin n_bad++; $display("FAIL wrap_a_last got %h want %h", oa_q[65535], ea_q[65535]); end
    endtask

    task automatic test_async_reset();
        snap_t z;
        clearq();
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < 20; i++) cyc(1'b1, 1'b0, $urandom | 32'h1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        z = '0; z.rdy = 1'b1;
        n_cmp++; if (obs_a() !== z) begin n_bad++; $display("FAIL async_reset_a got %h want %h", obs_a(), z); end
        n_cmp++; if (obs_b() !== z) begin n_bad++; $display("FAIL async_reset_b got %h want %h", obs_b(), z); end
        in_valid = 1'b0; in_sof = 1'b0;
        mreset();
        clearq();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, $urandom, 1'b0);
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 1; i < 40; i++) cyc(1'b1, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < ea_q.size(); i++) begin
            n_cmp++; if (oa_q[i] !== ea_q[i]) begin n_bad++; if (n_bad < 30) $display("FAIL post_reset_a cyc %0d got %h want %h", i, oa_q[i], ea_q[i]); end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_sof = 1'b0; hold = 1'b0; in_data = 32'd0; reset_n = 1'b0;
        test_reset();
        test_frame();
        test_discard();
        test_resync();
        test_timeout();
        test_hold();
        test_random();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
